// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//
// Purpose:
//   Shared definitions for the core's data-memory path: access-size encodings,
//   the dmem_responder FSM state type, the load/store ALU opcodes that execute
//   maps onto req_we, and small lane helpers used by the responder.
//
// Contents:
//   size_e       : SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD
//   state_e      : IDLE, BUSY, ACCESS, RESP
//   ALUOP_LOAD   : 6'b001100
//   ALUOP_STORE  : 6'b001101
//   byteEnable   : byte-lane write mask for a size and address offset
//   laneReplicate: store data copied across every lane of its size
//   loadExtract  : lane selection plus sign/zero extension for loads
// ---------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } state_e;

  localparam logic [5:0] ALUOP_LOAD  = 6'b001100;
  localparam logic [5:0] ALUOP_STORE = 6'b001101;

  // A misaligned half never reaches the write path, so the shifted mask
  // always stays inside the four lanes.
  function automatic logic [3:0] byteEnable(input size_e size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = 4'b0011 << lane;
      SZ_WORD: be = 4'hF;
      default: be = 4'h0;
    endcase
    return be;
  endfunction

  // Replicating the data means the byte-enable mask alone picks the lane.
  function automatic logic [31:0] laneReplicate(input size_e size, input logic [31:0] wdata);
    logic [31:0] data;
    case (size)
      SZ_BYTE: data = {4{wdata[7:0]}};
      SZ_HALF: data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

  function automatic logic [31:0] loadExtract(input size_e size, input logic [1:0] lane,
                                              input logic isUnsigned, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] data;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: data = isUnsigned ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: data = isUnsigned ? {16'h0, h} : {{16{h[15]}}, h};
      SZ_WORD: data = word;
      default: data = 32'h0;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
//
// Purpose:
//   Single-port synchronous data RAM, DEPTH_WORDS x 32 bits, with a 4-bit
//   byte write enable. Read data is registered: the word addressed in one
//   cycle appears on rdata_o in the next. Reads return the old contents when
//   the same word is written in the same cycle. Contents are never reset.
//
// Ports:
//   clk_i    in   1    clock, rising edge
//   be_i     in   4    byte write enables, bit n writes bits [8n+7:8n]
//   addr_i   in   AW   word index
//   wdata_i  in   32   write data
//   rdata_o  out  32   registered read data
// ---------------------------------------------------------------------------
module dmem_array #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes and the registered read share one port and one address.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Data-memory responder for the load/store path. Accepts one request on a
//   valid/ready handshake, waits WAIT_CYCLES cycles, performs the RAM access
//   and returns extended load data or an error on a valid/ready response
//   channel. Only one request is in flight; nothing is queued.
//
// Parameters:
//   DEPTH_WORDS  words of RAM (power of two)
//   WAIT_CYCLES  wait states before the access, 0..15
//   BASE_ADDR    byte address of word 0, aligned to DEPTH_WORDS*4
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid / req_ready     request handshake
//   req_we                    1 = store, 0 = load
//   req_addr                  byte address
//   req_wdata                 store data (lanes from the low bits)
//   req_size                  00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned              zero-extend loads when 1
//   rsp_valid / rsp_ready     response handshake
//   rsp_rdata                 extended load data, 0 for stores and errors
//   rsp_err                   misaligned, out-of-range or reserved size
//
// Optional feature (macro DMEM_STATS_EN):
//   stat_loads, stat_stores, stat_errs: 32-bit wrapping counters of completed
//   responses; errored requests only count in stat_errs.
// ---------------------------------------------------------------------------
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q;
  logic [3:0]  waitCnt_q;
  logic        capWe_q;
  logic [31:0] capAddr_q;
  logic [31:0] capWdata_q;
  size_e       capSize_q;
  logic        capUnsigned_q;
  logic        reqReady_q;
  logic        rspValid_q;
  logic [31:0] rspRdata_q;
  logic        rspErr_q;

  logic          accept;
  logic [31:0]   offset_d;
  logic          outOfRange_d;
  logic          misaligned_d;
  logic          accessErr_d;
  logic [31:0]   accessRdata_d;
  logic [AW-1:0] ramIdx_d;
  logic [3:0]    ramBe_d;
  logic [31:0]   ramWdata_d;
  logic [31:0]   ramRdata;

  assign accept = req_valid && reqReady_q;

  // Error classification and RAM port drive. The RAM read is registered, so
  // the index must already be valid in the cycle before ACCESS: in IDLE it
  // comes straight from the request (covers WAIT_CYCLES=0), afterwards from
  // the captured address. Because BASE_ADDR is aligned to the RAM size, the
  // word index is just the address bits above the byte offset.
  always_comb begin
    offset_d     = capAddr_q - BASE_ADDR;
    outOfRange_d = {1'b0, offset_d} >= (33'(DEPTH_WORDS) << 2);
    misaligned_d = 1'b0;
    case (capSize_q)
      SZ_HALF: misaligned_d = capAddr_q[0];
      SZ_WORD: misaligned_d = |capAddr_q[1:0];
      default: misaligned_d = 1'b0;
    endcase
    accessErr_d = misaligned_d || outOfRange_d || (capSize_q == SZ_RSVD);

    if (capWe_q || accessErr_d) begin
      accessRdata_d = 32'h0;
    end else begin
      accessRdata_d = loadExtract(capSize_q, capAddr_q[1:0], capUnsigned_q, ramRdata);
    end

    ramIdx_d   = (state_q == IDLE) ? req_addr[AW+1:2] : capAddr_q[AW+1:2];
    ramWdata_d = laneReplicate(capSize_q, capWdata_q);
    ramBe_d    = 4'h0;
    if (state_q == ACCESS && capWe_q && !accessErr_d) begin
      ramBe_d = byteEnable(capSize_q, capAddr_q[1:0]);
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk),
    .be_i   (ramBe_d),
    .addr_i (ramIdx_d),
    .wdata_i(ramWdata_d),
    .rdata_o(ramRdata)
  );

`ifdef DMEM_STATS_EN
  logic [31:0] statLoads_q;
  logic [31:0] statStores_q;
  logic [31:0] statErrs_q;
`endif

  // Request/response FSM with all handshake outputs registered. req_ready
  // resets low and rises on the first edge spent in IDLE, so it also stays
  // low until the cycle after a response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      waitCnt_q     <= 4'd0;
      capWe_q       <= 1'b0;
      capAddr_q     <= 32'h0;
      capWdata_q    <= 32'h0;
      capSize_q     <= SZ_BYTE;
      capUnsigned_q <= 1'b0;
      reqReady_q    <= 1'b0;
      rspValid_q    <= 1'b0;
      rspRdata_q    <= 32'h0;
      rspErr_q      <= 1'b0;
`ifdef DMEM_STATS_EN
      statLoads_q   <= 32'h0;
      statStores_q  <= 32'h0;
      statErrs_q    <= 32'h0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          reqReady_q <= 1'b1;
          if (accept) begin
            capWe_q       <= req_we;
            capAddr_q     <= req_addr;
            capWdata_q    <= req_wdata;
            capSize_q     <= size_e'(req_size);
            capUnsigned_q <= req_unsigned;
            reqReady_q    <= 1'b0;
            waitCnt_q     <= 4'd0;
            state_q       <= (WAIT_CYCLES == 0) ? ACCESS : BUSY;
          end
        end
        BUSY: begin
          if (waitCnt_q == 4'(WAIT_CYCLES - 1)) begin
            waitCnt_q <= 4'd0;
            state_q   <= ACCESS;
          end else begin
            waitCnt_q <= waitCnt_q + 4'd1;
          end
        end
        ACCESS: begin
          rspValid_q <= 1'b1;
          rspErr_q   <= accessErr_d;
          rspRdata_q <= accessRdata_d;
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRdata_q <= 32'h0;
            reqReady_q <= 1'b1;
            state_q    <= IDLE;
`ifdef DMEM_STATS_EN
            if (rspErr_q) begin
              statErrs_q <= statErrs_q + 32'd1;
            end else if (capWe_q) begin
              statStores_q <= statStores_q + 32'd1;
            end else begin
              statLoads_q <= statLoads_q + 32'd1;
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = reqReady_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;

`ifdef DMEM_STATS_EN
  assign stat_loads  = statLoads_q;
  assign stat_stores = statStores_q;
  assign stat_errs   = statErrs_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder with WAIT_CYCLES=1, DEPTH_WORDS=1024 and
// BASE_ADDR=0. Inputs change on the falling edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads;
  logic [31:0] stat_stores;
  logic [31:0] stat_errs;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;
  localparam logic [1:0] R = 2'b11;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(1),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
`ifdef DMEM_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  // One comparison: counts it, and on mismatch counts the error and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives a request from a falling edge, waits (bounded) for req_ready,
  // lets the rising edge accept it and drops req_valid on the next falling edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size,
                               input logic uns);
    int n;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    req_valid    = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Counts cycles from acceptance to the first sample with rsp_valid high.
  task automatic waitResponse(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full transaction with rsp_ready already high, checking data, error and latency.
  task automatic runTxn(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input logic [31:0] expRdata, input logic expErr);
    int lat;
    rsp_ready = 1'b1;
    applyStimulus(we, addr, wdata, size, uns);
    waitResponse(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
    checkOutput({tag, "_rdata"}, rsp_rdata, expRdata);
    checkOutput({tag, "_err"}, {31'b0, rsp_err}, {31'b0, expErr});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    rsp_ready    = 1'b0;

    $display("[TB] reset checks");
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'b0, req_ready}, 32'd1);

    $display("[TB] word store/load and lane extraction");
    runTxn("st_w_10", 1'b1, 32'h10, 32'hDEADBEEF, W, 1'b0, 32'h0, 1'b0);
    runTxn("ld_w_10", 1'b0, 32'h10, 32'h0, W, 1'b0, 32'hDEADBEEF, 1'b0);
    runTxn("ld_bs_13", 1'b0, 32'h13, 32'h0, B, 1'b0, 32'hFFFFFFDE, 1'b0);
    runTxn("ld_bu_13", 1'b0, 32'h13, 32'h0, B, 1'b1, 32'h000000DE, 1'b0);
    runTxn("ld_bs_10", 1'b0, 32'h10, 32'h0, B, 1'b0, 32'hFFFFFFEF, 1'b0);
    runTxn("ld_bu_11", 1'b0, 32'h11, 32'h0, B, 1'b1, 32'h000000BE, 1'b0);
    runTxn("ld_hs_10", 1'b0, 32'h10, 32'h0, H, 1'b0, 32'hFFFFBEEF, 1'b0);
    runTxn("ld_hu_12", 1'b0, 32'h12, 32'h0, H, 1'b1, 32'h0000DEAD, 1'b0);

    $display("[TB] partial stores");
    runTxn("st_h_12", 1'b1, 32'h12, 32'hABCD1234, H, 1'b0, 32'h0, 1'b0);
    runTxn("ld_w_10_h", 1'b0, 32'h10, 32'h0, W, 1'b0, 32'h1234BEEF, 1'b0);
    runTxn("st_b_11", 1'b1, 32'h11, 32'hAAAAAA5A, B, 1'b0, 32'h0, 1'b0);
    runTxn("ld_w_10_b", 1'b0, 32'h10, 32'h0, W, 1'b0, 32'h12345AEF, 1'b0);

    $display("[TB] error cases");
    runTxn("ld_w_11_mis", 1'b0, 32'h11, 32'h0, W, 1'b0, 32'h0, 1'b1);
    runTxn("ld_h_13_mis", 1'b0, 32'h13, 32'h0, H, 1'b0, 32'h0, 1'b1);
    runTxn("ld_rsvd", 1'b0, 32'h10, 32'h0, R, 1'b0, 32'h0, 1'b1);
    runTxn("st_h_11_mis", 1'b1, 32'h11, 32'h0000FFFF, H, 1'b0, 32'h0, 1'b1);
    runTxn("st_w_0", 1'b1, 32'h0, 32'h01020304, W, 1'b0, 32'h0, 1'b0);
    runTxn("st_w_last", 1'b1, 32'hFFC, 32'hCAFEF00D, W, 1'b0, 32'h0, 1'b0);
    runTxn("st_w_oor", 1'b1, 32'h1000, 32'h11111111, W, 1'b0, 32'h0, 1'b1);
    runTxn("ld_w_last", 1'b0, 32'hFFC, 32'h0, W, 1'b0, 32'hCAFEF00D, 1'b0);
    runTxn("ld_w_0", 1'b0, 32'h0, 32'h0, W, 1'b0, 32'h01020304, 1'b0);
    runTxn("ld_w_oor", 1'b0, 32'h1000, 32'h0, W, 1'b0, 32'h0, 1'b1);

    $display("[TB] response back-pressure");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h10, 32'h0, W, 1'b0);
    waitResponse(lat);
    checkOutput("bp_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("bp_rsp_rdata", rsp_rdata, 32'h12345AEF);
      checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
      if (i == 1) begin
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hFFFFFFFF;
        req_size  = W;
        req_valid = 1'b1;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_valid_cleared", {31'b0, rsp_valid}, 32'd0);
    checkOutput("bp_ready_back", {31'b0, req_ready}, 32'd1);
    runTxn("ld_w_10_after_bp", 1'b0, 32'h10, 32'h0, W, 1'b0, 32'h12345AEF, 1'b0);

    $display("[TB] reset during BUSY");
    runTxn("st_w_20", 1'b1, 32'h20, 32'h0BADF00D, W, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h20, 32'h77777777, W, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("midrst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("midrst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("postrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    runTxn("ld_w_20_old", 1'b0, 32'h20, 32'h0, W, 1'b0, 32'h0BADF00D, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
